// File: rtl/hud_layer_compositor_if.sv
// -----------------------------------------------------------------------------
// hud_layer_compositor_if
// Streaming bundle between the HUD object layers and the HUD compositor.
//   startOfFrame      : one-cycle pulse at frame start
//   layerReq          : per-layer drawing request (index 0 = highest priority)
//   layerRGB          : per-layer colour, packed [NUM_LAYERS-1:0][RGB_W-1:0]
//   layerEnable       : static per-layer enable
//   blinkMask         : layers subject to frame-synchronous blinking
//   flashTrigger      : one-cycle pulse that starts or restarts the HUD flash
//   HUDdrawingRequest : registered, some layer won this pixel
//   outRGB            : registered colour of the winning layer
//   flashActive       : high while the flash effect runs
// master = pixel source / game logic side, slave = compositor.
// -----------------------------------------------------------------------------
interface hud_layer_compositor_if #(
   parameter int NUM_LAYERS = 8,
   parameter int RGB_W      = 8
);
   logic                                startOfFrame;
   logic [NUM_LAYERS-1:0]               layerReq;
   logic [NUM_LAYERS-1:0][RGB_W-1:0]    layerRGB;
   logic [NUM_LAYERS-1:0]               layerEnable;
   logic [NUM_LAYERS-1:0]               blinkMask;
   logic                                flashTrigger;
   logic                                HUDdrawingRequest;
   logic [RGB_W-1:0]                    outRGB;
   logic                                flashActive;

   modport master (
      output startOfFrame, layerReq, layerRGB, layerEnable, blinkMask, flashTrigger,
      input  HUDdrawingRequest, outRGB, flashActive
   );

   modport slave (
      input  startOfFrame, layerReq, layerRGB, layerEnable, blinkMask, flashTrigger,
      output HUDdrawingRequest, outRGB, flashActive
   );
endinterface

// File: rtl/hud_layer_compositor.sv
// -----------------------------------------------------------------------------
// hud_layer_compositor
// N-layer fixed-priority compositor for the HUD path with per-layer enable,
// colour-key transparency, frame-synchronous blinking and a timed whole-HUD
// flash. Request and colour are registered together (1 clk latency).
// Ports:
//   clk    : pixel clock
//   resetN : asynchronous active-low reset
//   hud    : hud_layer_compositor_if.slave (layer inputs, composited outputs)
// -----------------------------------------------------------------------------
module hud_layer_compositor #(
   parameter int               NUM_LAYERS          = 8,
   parameter int               RGB_W               = 8,
   parameter logic [RGB_W-1:0] TRANSPARENT_RGB     = 8'hFF,
   parameter int               BLINK_PERIOD_FRAMES = 32,
   parameter int               FLASH_FRAMES        = 20,
   parameter logic [RGB_W-1:0] FLASH_RGB           = 8'hE0
) (
   input  logic                  clk,
   input  logic                  resetN,
   hud_layer_compositor_if.slave hud
);

   localparam int BLINK_W = $clog2(BLINK_PERIOD_FRAMES);
   localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);

   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD_FRAMES - 1);
   localparam logic [BLINK_W-1:0] BLINK_HALF = BLINK_W'(BLINK_PERIOD_FRAMES / 2);
   localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_FRAMES);

   typedef enum logic {IDLE, FLASH} flash_state_t;

   logic [BLINK_W-1:0]    r_blinkCnt;
   logic [FLASH_W-1:0]    r_flashCnt;
   flash_state_t          r_state;
   logic                  r_HUDdrawingRequest;
   logic [RGB_W-1:0]      r_outRGB;

   flash_state_t          w_nextState;
   logic [FLASH_W-1:0]    w_nextFlashCnt;
   logic                  w_blinkHidden;
   logic [NUM_LAYERS-1:0] w_eff;
   logic                  w_winFound;
   logic [RGB_W-1:0]      w_winRGB;

   // ---------------- blink counter ----------------
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_blinkCnt <= '0;
      end else if (hud.startOfFrame) begin
         r_blinkCnt <= (r_blinkCnt == BLINK_LAST) ? '0 : r_blinkCnt + 1'b1;
      end
   end

   // First half of each period visible, second half hidden.
   assign w_blinkHidden = (r_blinkCnt >= BLINK_HALF);

   // ---------------- flash FSM ----------------
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state    <= IDLE;
         r_flashCnt <= '0;
      end else begin
         r_state    <= w_nextState;
         r_flashCnt <= w_nextFlashCnt;
      end
   end

   // NOTE: every combinational output gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      w_nextState    = r_state;
      w_nextFlashCnt = r_flashCnt;
      case (r_state)
         IDLE: begin
            if (hud.flashTrigger) begin
               w_nextState    = FLASH;
               w_nextFlashCnt = FLASH_LOAD;
            end
         end
         FLASH: begin
            // A trigger reloads and masks a coincident frame pulse.
            if (hud.flashTrigger) begin
               w_nextFlashCnt = FLASH_LOAD;
            end else if (hud.startOfFrame) begin
               if (r_flashCnt == FLASH_W'(1)) begin
                  w_nextState    = IDLE;
                  w_nextFlashCnt = '0;
               end else begin
                  w_nextFlashCnt = r_flashCnt - 1'b1;
               end
            end
         end
         default: begin
            w_nextState    = IDLE;
            w_nextFlashCnt = '0;
         end
      endcase
   end

   // ---------------- effective requests and priority select ----------------
   always_comb begin
      w_eff = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         w_eff[i] = hud.layerReq[i] & hud.layerEnable[i]
                  & ~(hud.blinkMask[i] & w_blinkHidden)
                  & (hud.layerRGB[i] != TRANSPARENT_RGB);
      end
   end

   // Scan from lowest priority upward so the lowest drawing index wins last.
   always_comb begin
      w_winFound = 1'b0;
      w_winRGB   = '0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (w_eff[i]) begin
            w_winFound = 1'b1;
            w_winRGB   = hud.layerRGB[i];
         end
      end
   end

   // ---------------- registered outputs ----------------
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_HUDdrawingRequest <= 1'b0;
         r_outRGB            <= '0;
      end else begin
         r_HUDdrawingRequest <= w_winFound;
         if (!w_winFound) begin
            r_outRGB <= '0;
         end else if (r_state == FLASH) begin
            r_outRGB <= FLASH_RGB;
         end else begin
            r_outRGB <= w_winRGB;
         end
      end
   end

   assign hud.HUDdrawingRequest = r_HUDdrawingRequest;
   assign hud.outRGB            = r_outRGB;
   assign hud.flashActive       = (r_state == FLASH);

endmodule

// File: tb/tb_hud_layer_compositor.sv
// -----------------------------------------------------------------------------
// tb_hud_layer_compositor
// Self-checking bench for hud_layer_compositor: a vector table for the static
// priority/transparency/enable rules, hand-written blink, flash and reset
// sequences, and a randomized run compared against a frame-level model.
// -----------------------------------------------------------------------------
module tb_hud_layer_compositor;

   localparam int N        = 8;
   localparam int W        = 8;
   localparam int BLINK    = 32;
   localparam int FLASH_N  = 20;
   localparam logic [W-1:0] KEY_RGB   = 8'hFF;
   localparam logic [W-1:0] FLASH_COL = 8'hE0;

   logic clk;
   logic resetN;

   hud_layer_compositor_if #(.NUM_LAYERS(N), .RGB_W(W)) bus ();

   hud_layer_compositor #(
      .NUM_LAYERS(N), .RGB_W(W), .TRANSPARENT_RGB(KEY_RGB),
      .BLINK_PERIOD_FRAMES(BLINK), .FLASH_FRAMES(FLASH_N), .FLASH_RGB(FLASH_COL)
   ) dut (
      .clk    (clk),
      .resetN (resetN),
      .hud    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Frame-level model: frames seen since reset, frames of flash still owed.
   int m_frames;
   int m_flash_left;
   logic         exp_req;
   logic [W-1:0] exp_rgb;
   logic         exp_active;

   typedef struct {
      string                  name;
      logic [N-1:0]           req;
      logic [N-1:0][W-1:0]    rgb;
      logic [N-1:0]           en;
      logic                   e_req;
      logic [W-1:0]           e_rgb;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_total++;
      if (actual !== expected) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic model_reset();
      m_frames     = 0;
      m_flash_left = 0;
   endtask

   // Apply current inputs for one clock; model predicts the registered result.
   task automatic tick(input bit check_model);
      int  win;
      bit  hidden;
      hidden = (m_frames % BLINK) >= (BLINK / 2);
      win = -1;
      for (int i = 0; i < N; i++) begin
         if (win < 0 && bus.layerReq[i] && bus.layerEnable[i]
             && !(bus.blinkMask[i] && hidden) && bus.layerRGB[i] != KEY_RGB)
            win = i;
      end
      exp_req = (win >= 0);
      if (win < 0)               exp_rgb = '0;
      else if (m_flash_left > 0) exp_rgb = FLASH_COL;
      else                       exp_rgb = bus.layerRGB[win];
      if (bus.flashTrigger)                          m_flash_left = FLASH_N;
      else if (bus.startOfFrame && m_flash_left > 0) m_flash_left--;
      if (bus.startOfFrame) m_frames++;
      exp_active = (m_flash_left > 0);
      @(posedge clk);
      #1;
      bus.startOfFrame = 1'b0;
      bus.flashTrigger = 1'b0;
      if (check_model) begin
         check("rand_req",    32'(bus.HUDdrawingRequest), 32'(exp_req));
         check("rand_rgb",    32'(bus.outRGB),            32'(exp_rgb));
         check("rand_active", 32'(bus.flashActive),       32'(exp_active));
      end
   endtask

   task automatic frame_pulse();
      bus.startOfFrame = 1'b1;
      tick(1'b0);
   endtask

   task automatic clear_inputs();
      bus.startOfFrame = 1'b0;
      bus.flashTrigger = 1'b0;
      bus.layerReq     = '0;
      bus.layerRGB     = '0;
      bus.layerEnable  = '1;
      bus.blinkMask    = '0;
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      resetN = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- vector table ----------------
      foreach (vecs[k]) begin
         vecs[k].rgb = '0;
         vecs[k].en  = '1;
      end
      vecs[0].name = "prio_2_over_5"; vecs[0].req = 8'b0010_0100;
      vecs[0].rgb[2] = 8'h1C; vecs[0].rgb[5] = 8'h03; vecs[0].e_req = 1'b1; vecs[0].e_rgb = 8'h1C;
      vecs[1].name = "prio_only_5";   vecs[1].req = 8'b0010_0000;
      vecs[1].rgb[2] = 8'h1C; vecs[1].rgb[5] = 8'h03; vecs[1].e_req = 1'b1; vecs[1].e_rgb = 8'h03;
      vecs[2].name = "colour_key";    vecs[2].req = 8'b0000_1001;
      vecs[2].rgb[0] = 8'hFF; vecs[2].rgb[3] = 8'h5A; vecs[2].e_req = 1'b1; vecs[2].e_rgb = 8'h5A;
      vecs[3].name = "enable_off";    vecs[3].req = 8'b0000_1001; vecs[3].en = 8'b1111_0111;
      vecs[3].rgb[0] = 8'hFF; vecs[3].rgb[3] = 8'h5A; vecs[3].e_req = 1'b0; vecs[3].e_rgb = 8'h00;
      vecs[4].name = "no_request";    vecs[4].req = 8'h00;
      vecs[4].rgb[1] = 8'h77; vecs[4].e_req = 1'b0; vecs[4].e_rgb = 8'h00;
      vecs[5].name = "all_req_l0";    vecs[5].req = 8'hFF;
      vecs[5].rgb[0] = 8'h07; vecs[5].rgb[7] = 8'h70; vecs[5].e_req = 1'b1; vecs[5].e_rgb = 8'h07;

      // ---------------- reset state ----------------
      resetN = 1'b0;
      clear_inputs();
      model_reset();
      bus.layerReq = 8'h01;
      bus.layerRGB[0] = 8'h10;
      repeat (2) @(posedge clk);
      #1;
      check("reset_req",    32'(bus.HUDdrawingRequest), 32'd0);
      check("reset_rgb",    32'(bus.outRGB),            32'd0);
      check("reset_active", 32'(bus.flashActive),       32'd0);
      resetN = 1'b1;
      clear_inputs();

      foreach (vecs[k]) begin
         bus.layerReq    = vecs[k].req;
         bus.layerRGB    = vecs[k].rgb;
         bus.layerEnable = vecs[k].en;
         tick(1'b0);
         check({vecs[k].name, "_req"}, 32'(bus.HUDdrawingRequest), 32'(vecs[k].e_req));
         check({vecs[k].name, "_rgb"}, 32'(bus.outRGB),            32'(vecs[k].e_rgb));
      end

      // ---------------- blink: 64 frames ----------------
      do_reset();
      bus.blinkMask   = 8'b0000_0010;
      bus.layerReq    = 8'b0000_0010;
      bus.layerRGB[1] = 8'h44;
      for (int f = 0; f <= 64; f++) begin
         bit vis;
         vis = ((f % 32) < 16);
         tick(1'b0);
         check($sformatf("blink_req_f%0d", f), 32'(bus.HUDdrawingRequest), 32'(vis));
         check($sformatf("blink_rgb_f%0d", f), 32'(bus.outRGB), vis ? 32'h44 : 32'h0);
         if (f < 64) frame_pulse();
      end

      // ---------------- flash ----------------
      do_reset();
      bus.layerReq    = 8'h01;
      bus.layerRGB[0] = 8'h10;
      tick(1'b0);
      check("pre_flash_rgb", 32'(bus.outRGB), 32'h10);
      bus.flashTrigger = 1'b1;
      tick(1'b0);
      check("flash_rise", 32'(bus.flashActive), 32'd1);
      for (int p = 0; p < FLASH_N; p++) begin
         tick(1'b0);
         check($sformatf("flash_active_p%0d", p), 32'(bus.flashActive), 32'd1);
         check($sformatf("flash_rgb_p%0d", p),    32'(bus.outRGB),      32'hE0);
         frame_pulse();
      end
      check("flash_fall", 32'(bus.flashActive), 32'd0);
      tick(1'b0);
      check("post_flash_rgb",    32'(bus.outRGB),      32'h10);
      check("post_flash_active", 32'(bus.flashActive), 32'd0);

      // Retrigger with coincident frame pulse when 5 frames remain.
      bus.flashTrigger = 1'b1;
      tick(1'b0);
      repeat (FLASH_N - 5) frame_pulse();
      check("retrig_before", 32'(bus.flashActive), 32'd1);
      bus.flashTrigger = 1'b1;
      bus.startOfFrame = 1'b1;
      tick(1'b0);
      for (int p = 1; p <= FLASH_N; p++) begin
         frame_pulse();
         check($sformatf("retrig_active_p%0d", p), 32'(bus.flashActive), (p < FLASH_N) ? 32'd1 : 32'd0);
      end

      // ---------------- reset mid-flash, blinkCnt = 20 ----------------
      do_reset();
      bus.layerReq    = 8'h01;
      bus.layerRGB[0] = 8'h10;
      repeat (20) frame_pulse();
      bus.flashTrigger = 1'b1;
      tick(1'b0);
      tick(1'b0);
      check("mid_flash_rgb", 32'(bus.outRGB), 32'hE0);
      #2;
      resetN = 1'b0;
      #1;
      check("async_rst_req",    32'(bus.HUDdrawingRequest), 32'd0);
      check("async_rst_rgb",    32'(bus.outRGB),            32'd0);
      check("async_rst_active", 32'(bus.flashActive),       32'd0);
      model_reset();
      #1;
      resetN = 1'b1;
      @(posedge clk);
      #1;
      // Blink-masked layer must be visible: counter restarted at 0, not 20.
      bus.blinkMask = 8'h01;
      tick(1'b0);
      check("rst_blink_visible", 32'(bus.outRGB),      32'h10);
      check("rst_flash_idle",    32'(bus.flashActive), 32'd0);
      repeat (16) frame_pulse();
      tick(1'b0);
      check("rst_blink_hidden", 32'(bus.HUDdrawingRequest), 32'd0);

      // ---------------- randomized run against the model ----------------
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         bus.layerReq    = 8'($urandom);
         bus.layerEnable = 8'($urandom) | 8'($urandom);
         bus.blinkMask   = 8'($urandom);
         for (int i = 0; i < N; i++)
            bus.layerRGB[i] = ($urandom_range(0, 3) == 0) ? KEY_RGB : 8'($urandom);
         bus.startOfFrame = ($urandom_range(0, 15) == 0);
         bus.flashTrigger = ($urandom_range(0, 299) == 0);
         tick(1'b1);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/hud_layer_compositor.md
# hud_layer_compositor

Parametrised N-layer priority compositor for the HUD path: it merges any number of HUD object layers (panel, lives, heart, level digits, score digits, countdown, and later additions) into one RGB stream and one drawing request for the top-level video mux. Beyond fixed-priority selection it adds:

- per-layer enable;
- colour-key transparency;
- frame-synchronous blinking of selected layers;
- a timed whole-HUD flash effect, triggered by game logic (hit, level-up).

Output request and colour are registered together, so they are always cycle-aligned.

## Interface
Parameters:
- NUM_LAYERS, 8, number of input layers; index 0 = highest priority
- RGB_W, 8, colour width per layer
- TRANSPARENT_RGB, 8'hFF, colour key; a layer pixel equal to this is treated as not drawing
- BLINK_PERIOD_FRAMES, 32, blink period in frames; even, ≥2
- FLASH_FRAMES, 20, flash duration in frames; ≥1
- FLASH_RGB, 8'hE0, colour substituted during flash

Ports:
- clk, input, 1, pixel clock
- resetN, input, 1, asynchronous active-low reset
- startOfFrame, input, 1, one-cycle pulse at frame start
- layerReq, input, NUM_LAYERS, per-layer drawing request
- layerRGB, input, NUM_LAYERS×RGB_W, per-layer colour; packed [NUM_LAYERS-1:0][RGB_W-1:0]
- layerEnable, input, NUM_LAYERS, static per-layer enable
- blinkMask, input, NUM_LAYERS, layers subject to blinking
- flashTrigger, input, 1, one-cycle pulse that starts or restarts the flash
- HUDdrawingRequest, output, 1, registered: any layer won this pixel
- outRGB, output, RGB_W, registered colour of the winning layer
- flashActive, output, 1, high while the flash FSM is in FLASH

## Operation
**Blink counter**
- blinkCnt, width $clog2(BLINK_PERIOD_FRAMES).
- Increments on each startOfFrame; wraps from BLINK_PERIOD_FRAMES-1 to 0.
- blinkHidden = (blinkCnt ≥ BLINK_PERIOD_FRAMES/2). Each period is visible first, hidden second.

**Effective request, per layer i**
- eff[i] = layerReq[i] & layerEnable[i] & ~(blinkMask[i] & blinkHidden) & (layerRGB[i] != TRANSPARENT_RGB).

**Selection**
- Winner = lowest i with eff[i] = 1.
- No eff bit set: HUDdrawingRequest = 0 and outRGB = 0. Outputs are always defined, never held.

**Flash FSM, states IDLE and FLASH**
- IDLE → FLASH on flashTrigger; flashCnt loads FLASH_FRAMES.
- In FLASH, each startOfFrame decrements flashCnt. A startOfFrame that finds flashCnt = 1 returns to IDLE and sets flashCnt to 0.
- flashTrigger in FLASH reloads flashCnt to FLASH_FRAMES.
- flashTrigger and startOfFrame in the same cycle: the reload wins and no decrement occurs.
- While in FLASH, any winning pixel outputs FLASH_RGB instead of the layer colour. HUDdrawingRequest is unchanged.
- flashCnt width: $clog2(FLASH_FRAMES+1).

**Reset (asynchronous)**
- Outputs: HUDdrawingRequest = 0, outRGB = 0, flashActive = 0.
- Internal: blinkCnt = 0, flashCnt = 0, state IDLE.
- Reset mid-flash aborts the flash immediately.

## Timing
- Latency is 1 clk from layerReq/layerRGB to HUDdrawingRequest/outRGB. Both outputs update on the same edge.
- layerEnable, blinkMask and blinkHidden are sampled in the same cycle as the pixel.
- A blinkCnt change caused by startOfFrame affects pixels sampled from the next cycle onward.
- The FSM registers the transition on the flashTrigger edge.
  - flashActive rises 1 clk after the trigger.
  - FLASH_RGB substitution applies to pixels sampled from the cycle after the trigger.
- Flash length is FLASH_FRAMES startOfFrame pulses after the trigger. flashActive falls 1 clk after the final pulse.
- No handshakes; the block is purely streaming with one pixel per clk.

## Test plan
- **Priority:** layerReq = 8'b0010_0100, layerRGB[2] = 8'h1C, layerRGB[5] = 8'h03, all enabled → next cycle HUDdrawingRequest = 1, outRGB = 8'h1C. Clear bit 2 → outRGB = 8'h03.
- **Transparency/enable:** layerReq[0] = 1, layerRGB[0] = 8'hFF, layerReq[3] = 1, layerRGB[3] = 8'h5A → outRGB = 8'h5A. Then layerEnable[3] = 0 → HUDdrawingRequest = 0, outRGB = 0.
- **Blink:** blinkMask[1] = 1, layerReq[1] held at 1, RGB = 8'h44, 64 frame pulses → output is 8'h44 during frames 0–15 and 32–47, and request = 0 during frames 16–31 and 48–63. Wrap-around is confirmed after pulse 32.
- **Flash:** flashTrigger pulse, layer 0 drawing 8'h10 → flashActive = 1 for exactly 20 frame pulses with outRGB = 8'hE0, then outRGB = 8'h10. Retrigger with a simultaneous startOfFrame at count 5 → the flash lasts 20 further frames.
- **Reset mid-operation:** assert resetN = 0 mid-flash with blinkCnt = 20 → outputs go to 0 asynchronously. After release, blinkCnt restarts at 0 and flashActive = 0.
